uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL take parameter CLKS_PER_BIT, default 217, meaning clock cycles per serial bit (25 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all state is rising-edge.
REQ-003 SHALL have port RST, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port RX, input, 1, asynchronous serial line; idles high.
REQ-005 SHALL have port data, output, 8, the received byte, LSB first on the wire.
REQ-006 SHALL have port valid, output, 1, meaning data holds an unconsumed byte.
REQ-007 SHALL have port ready, input, 1, the consumer accepts data when valid && ready.
REQ-008 SHALL have port frame_err, output, 1, a one-cycle pulse when the stop bit samples low.
REQ-009 SHALL have port overrun, output, 1, a sticky flag set when a byte completes while valid=1 and ready=0; it clears only on reset.

Function
REQ-010 SHALL pass RX through a 2-flop synchronizer, preset to 1, before any use; the synchronized line is rx_s.
REQ-011 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-012 IDLE: on rx_s falling (1->0), go to START and load the bit counter with CLKS_PER_BIT/2 - 1.
REQ-013 START: at counter zero, if rx_s=0, go to DATA with counter CLKS_PER_BIT-1 and bit index 0; if rx_s=1, treat it as a glitch and return to IDLE with no output.
REQ-014 DATA: at each counter zero, shift rx_s into bit[index] and reload; after index 7 go to STOP.
REQ-015 STOP: at counter zero, if rx_s=1 the byte is good; if rx_s=0, pulse frame_err for one cycle and discard the byte; return to IDLE either way.
REQ-016 SHALL sample every bit at its midpoint, ±1 cycle.
REQ-017 SHALL deliver a good byte by writing data and setting valid on the cycle after the stop-bit sample, a latency of 1 cycle.
REQ-018 SHALL clear valid on a cycle with valid && ready, unless a new good byte completes on that same cycle; in that case valid stays 1, data takes the new byte, and overrun is not set.
REQ-019 On overrun (good byte completes, valid=1, ready=0), the new byte SHALL overwrite data, valid SHALL stay 1, and overrun SHALL set.
REQ-020 SHALL hold data stable while valid=1 and no new byte completes.
REQ-021 SHALL use a 16-bit counter; CLKS_PER_BIT/2 truncates.
REQ-022 SHALL allow a new start bit to be detected in IDLE on the cycle after STOP exits, with no dead time beyond that.
REQ-023 A break (RX held low) SHALL produce exactly one frame_err, then wait in IDLE for rx_s to rise and fall again before re-arming.

Reset
REQ-024 On RST=0, the block SHALL immediately go to state IDLE with counters 0, shift register 0, data=0, valid=0, frame_err=0, overrun=0, and synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output; after release, the receiver SHALL resynchronize on the next falling edge.
REQ-026 SHALL leave reset deassertion unsynchronized inside the block; the top level supplies a synchronized release.

Structure
REQ-027 SHALL place the FSM state encoding (2-bit enum) and default baud constants in shared package uart_pkg, which the sibling uart_tx also uses.
REQ-028 SHALL instantiate the synchronizer as sub-module sync2, a 2-flop synchronizer with a reset-value parameter.
REQ-029 SHALL be written so that it can be verified with RX looped back from uart_tx, as in the top-level bench.

Verification (CLKS_PER_BIT=8 for all)
REQ-030 Send byte 0xA5 (8N1), hold ready=0 -> valid rises 1 cycle after the stop sample, data=0xA5, frame_err=0, overrun=0.
REQ-031 Send 0x3C then 0xC3 back-to-back with ready=0 throughout -> data=0xC3, valid=1, overrun=1.
REQ-032 Send 0x00 with the stop bit forced low -> one frame_err pulse, valid stays 0, data unchanged.
REQ-033 Drive a 3-cycle low glitch on RX -> no valid, no frame_err, FSM back in IDLE by the midpoint check.
REQ-034 Assert RST=0 during bit 4 of 0xFF, release, then send 0x81 -> only 0x81 is delivered, with valid=1 and overrun=0.
REQ-035 Hold ready=1 and send 0x5A -> valid is high for exactly 1 cycle, with data=0x5A on that cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding and default baud constants
// Used by uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int unsigned DEF_CLK_HZ       = 25_000_000;
  localparam int unsigned DEF_BAUD         = 115_200;
  localparam int unsigned DEF_CLKS_PER_BIT = DEF_CLK_HZ / DEF_BAUD;  // 217

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with configurable reset value
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with valid/ready output and error flags
// Ports:
//   CLK       - system clock, rising edge
//   RST       - asynchronous active-low reset
//   RX        - asynchronous serial input, idles high
//   data      - received byte
//   valid     - data holds an unconsumed byte
//   ready     - consumer takes data when valid && ready
//   frame_err - one-cycle pulse when the stop bit samples low
//   overrun   - sticky, set when a byte lands on an unconsumed one
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_LOAD = 16'(CLKS_PER_BIT - 1);

  logic        rx_s;
  logic        rx_q;
  logic        rx_fall;

  uart_state_t state, state_next;
  logic [15:0] cnt, cnt_next;
  logic [2:0]  idx, idx_next;
  logic [7:0]  shreg, shreg_next;
  logic        byte_good;
  logic        byte_bad;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (CLK),
    .rst_n (RST),
    .d     (RX),
    .q     (rx_s)
  );

  // Edge detect on the synchronized line; a held-low break never re-arms
  // until the line has risen and fallen again.
  assign rx_fall = rx_q & ~rx_s;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      rx_q  <= 1'b1;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
      rx_q  <= rx_s;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    byte_good  = 1'b0;
    byte_bad   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rx_fall) begin
          state_next = ST_START;
          cnt_next   = HALF_LOAD;
        end
      end
      ST_START: begin
        if (cnt == 16'd0) begin
          if (!rx_s) begin
            state_next = ST_DATA;
            cnt_next   = FULL_LOAD;
            idx_next   = 3'd0;
          end else begin
            state_next = ST_IDLE;  // start bit gone at midpoint: glitch
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt == 16'd0) begin
          shreg_next[idx] = rx_s;
          cnt_next        = FULL_LOAD;
          if (idx == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            idx_next = idx + 3'd1;
          end
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt == 16'd0) begin
          state_next = ST_IDLE;
          byte_good  = rx_s;
          byte_bad   = ~rx_s;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A completing byte takes priority over consumption, so an accept on
  // the same cycle simply hands over to the new byte without overrun.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= byte_bad;
      if (byte_good) begin
        data  <= shreg;
        valid <= 1'b1;
        if (valid && !ready) begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
